// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: address/line
// widths, decoded opcodes, FSM state encoding and a saturating counter helper.
// Optional feature macro: FETCH_STEP_EN (adds the STEPWAIT state).
package fetch_ctrl_pkg;

  localparam int IP_WIDTH   = 8;
  localparam int LINE_WIDTH = 32;

  localparam logic [7:0] OP_JUMP = 8'h40;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    ISSUE    = 3'd3,
`ifdef FETCH_STEP_EN
    HALT     = 3'd4,
    STEPWAIT = 3'd5
`else
    HALT     = 3'd4
`endif
  } fetch_state_t;

  // Retired-instruction counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: fetches a line at pc, decodes HALT and JUMP
// locally, hands every other instruction to the execute unit and waits for
// exec_done before advancing (sequentially, or to a branch target).
// Optional feature macro: FETCH_STEP_EN adds a step input and a STEPWAIT
// state that pauses before every refetch until step is pulsed.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [LINE_WIDTH-1:0] line,
  output logic                  mem_en,
  output logic [IP_WIDTH-1:0]   ip,
  output logic [LINE_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  input  logic [IP_WIDTH-1:0]   branch_target,
`ifdef FETCH_STEP_EN
  input  logic                  step,
`endif
  output logic                  halted,
  output logic [15:0]           retired
);

  // Where DECODE/ISSUE go when they finish with the current instruction.
`ifdef FETCH_STEP_EN
  localparam fetch_state_t RESUME_STATE = STEPWAIT;
`else
  localparam fetch_state_t RESUME_STATE = FETCH;
`endif

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [IP_WIDTH-1:0]   r_pc;
  logic [IP_WIDTH-1:0]   w_pc_next;
  logic [LINE_WIDTH-1:0] r_instr;
  logic [LINE_WIDTH-1:0] w_instr_next;
  logic [15:0]           r_retired;
  logic [15:0]           w_retired_next;
  logic [7:0]            w_opcode;

  assign w_opcode = r_instr[31:24];

  // State, pc, instruction and retired-count registers; reset clears all.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_instr   <= w_instr_next;
      r_retired <= w_retired_next;
    end
  end

  // Next-state, pc update, line capture and retire counting.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_instr_next   = r_instr;
    w_retired_next = r_retired;
    case (r_state)
      IDLE: begin
        w_pc_next = '0;
        if (start) w_state_next = FETCH;
      end
      FETCH: begin
        w_instr_next = line;
        w_state_next = DECODE;
      end
      DECODE: begin
        if (w_opcode == OP_HALT) begin
          w_state_next = HALT;
        end else if (w_opcode == OP_JUMP) begin
          // Jumps complete here and never reach the execute unit.
          w_pc_next      = IP_WIDTH'(r_instr[23:16]);
          w_retired_next = sat_inc16(r_retired);
          w_state_next   = RESUME_STATE;
        end else begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        // branch_taken/branch_target only matter alongside exec_done.
        if (exec_done) begin
          w_pc_next      = branch_taken ? branch_target : r_pc + IP_WIDTH'(1);
          w_retired_next = sat_inc16(r_retired);
          w_state_next   = RESUME_STATE;
        end
      end
      HALT: begin
        if (start) begin
          w_pc_next      = '0;
          w_retired_next = '0;
          w_state_next   = FETCH;
        end
      end
`ifdef FETCH_STEP_EN
      STEPWAIT: begin
        if (step) w_state_next = FETCH;
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from state so reset drops them immediately.
  assign mem_en      = (r_state == FETCH);
  assign instr_valid = (r_state == ISSUE);
  assign halted      = (r_state == HALT);
  assign ip          = r_pc;
  assign instr       = r_instr;
  assign retired     = r_retired;

endmodule
